ysyx_22040759_rdarb: RTL
========================

# ysyx_22040759_rdarb

Two-requester read arbiter that shares the single AXI read master (`ysyx_22040759_rdaxi`) between instruction fetch (IF) and load (MEM). It grants one request at a time and latches that request's address and size. It drives the read master's request side until completion, then returns the data to the granted requester with a one-cycle ready pulse. A branch flush squashes an in-flight fetch response without aborting the bus transaction.

## Interface
Parameters:
- `ADDR_WIDTH`, default 64: request address width.
- `DATA_WIDTH`, default 64: read data width.

Ports:
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-high reset.
- `if_req_i` in 1: IF read request (level).
- `if_addr_i` in ADDR_WIDTH: IF address. Size is fixed at word (2'b10).
- `if_ready_o` out 1: one-cycle pulse; `if_data_o` is valid.
- `if_data_o` out DATA_WIDTH: IF response data.
- `flush_i` in 1: squash the in-flight IF response.
- `mem_req_i` in 1: MEM read request (level).
- `mem_addr_i` in ADDR_WIDTH: MEM address.
- `mem_size_i` in 2: 00 B, 01 H, 10 W, 11 D.
- `mem_ready_o` out 1: one-cycle pulse; `mem_data_o` is valid.
- `mem_data_o` out DATA_WIDTH: MEM response data.
- `rd_valid_o` out 1: request to the read master's `rd_addr_valid_i`.
- `rd_addr_o` out ADDR_WIDTH: latched address to the read master.
- `rd_size_o` out 2: latched size to the read master.
- `rd_done_i` in 1: the read master's `rd_data_valid_o` pulse.
- `rd_data_i` in DATA_WIDTH: the read master's `data_read_o`.

## Operation
States: IDLE, BUSY, RESP.

IDLE:
- If any request is asserted, grant one, latch `rd_addr_o`/`rd_size_o` and `grant` (IF/MEM), clear `kill`, and go to BUSY.
- Tie (both requests high): grant the requester that was not granted last (`last_grant`). `last_grant` resets to IF, so MEM wins the first tie.
- Single request: grant it.

BUSY:
- `rd_valid_o` = 1, driven combinationally from the state.
- `rd_addr_o` and `rd_size_o` are held stable for the whole transaction, because the read master uses them combinationally for its mask and alignment logic.
- On `rd_done_i`: capture `rd_data_i` into the granted requester's data register, update `last_grant`, and go to RESP.

RESP:
- Pulse the granted requester's ready for exactly one cycle. If `kill` is set, the IF ready is suppressed (the data register is still updated).
- Go to IDLE.

Arbitration:
- Arbitration happens only in IDLE, so a requester still holding `req` during its RESP cycle is never re-granted by mistake.

Requester contract:
- Hold `req` high until ready is seen.
- The address may change after grant; the latched copy is used.
- If a requester drops `req` mid-transaction, the transaction completes and the ready pulse is still issued.

Flush:
- `flush_i` in BUSY or RESP with `grant`=IF sets `kill`, which suppresses that `if_ready_o`.
- `flush_i` has no effect in IDLE or with `grant`=MEM.
- A flush and a new IF grant in the same IDLE cycle: the new grant stands and `kill` is cleared.

Other rules:
- `rd_done_i` outside BUSY is ignored.
- Data registers hold their last value between responses.
- Reset: all outputs, data registers, `kill` and `rd_addr_o`/`rd_size_o` are 0; state is IDLE; `last_grant` is IF.
- `rst` mid-transaction: the block returns to IDLE immediately. The read master shares `rst`, and `rst` must be held across at least one `clk` edge so both blocks reset together.

## Timing
- `rd_valid_o` must be low by the cycle after `rd_done_i`. The read master leaves WAIT for IDLE on that edge, so it must see `rd_valid_o` low there to avoid a spurious re-issue.
- Minimum latency, with the slave ready immediately: `req` high in IDLE at cycle 0 -> BUSY at cycle 1 -> read master ADDR at cycle 2 -> READ at cycle 3 -> `rd_done_i` at cycle 4 -> ready pulse at cycle 5 -> IDLE at cycle 6.
- Back-to-back issue: the next grant is decided at cycle 6, giving BUSY at cycle 7, so there are 6 cycles per transaction.
- Ready-to-data alignment: the data output updates on the same edge that raises ready, and holds afterwards.

## Test plan
- Single IF: `if_addr` = 0x8000_0004, read master returns 0x1111_2222_3333_4444 -> `rd_size_o` = 2'b10, `rd_addr_o` = 0x8000_0004; `if_ready_o` pulses at cycle 5 with `if_data_o` = 0x1111_2222_3333_4444; `mem_ready_o` stays 0.
- Simultaneous IF and MEM after reset, MEM size 11 at 0x8000_1000 -> MEM is granted first; after its ready, IF is granted next cycle-pair. A second tie goes to IF, then MEM (alternation).
- Address held during BUSY: change `mem_addr_i` every cycle after grant -> `rd_addr_o` stays at the latched value until RESP.
- Flush: IF granted, `flush_i` pulsed at cycle 3 -> `if_ready_o` never pulses; `if_data_o` updates; a queued MEM request is granted in the following IDLE.
- Asynchronous reset asserted mid-BUSY (between clock edges) -> `rd_valid_o`, ready and data outputs go to 0 immediately. After release, a fresh IF request completes normally.
- Stray `rd_done_i` in IDLE -> no ready pulse, no data update, no state change.

Source files
------------

// File: rtl/ysyx_22040759_rdarb.sv
// ----------------------------------------------------------------------------
// ysyx_22040759_rdarb
//
// Two-requester read arbiter that shares one AXI read master between
// instruction fetch (IF) and load (MEM).
//
// One request is granted at a time. Its address and size are latched and
// presented to the read master until that master reports completion. The
// returned data is then handed to the granted requester together with a
// one-cycle ready pulse. A branch flush squashes an in-flight fetch response
// without aborting the bus transaction.
//
// Handshake semantics:
//   * if_req_i / mem_req_i are level requests. A requester holds its request
//     until it sees its ready pulse.
//   * if_ready_o / mem_ready_o pulse for exactly one cycle. The matching data
//     output is valid in that cycle and holds its value afterwards.
//   * rd_valid_o is high for the whole time the read master is working on the
//     request. rd_addr_o / rd_size_o are stable for that whole time.
//   * rd_done_i is a one-cycle completion pulse. It is ignored unless a
//     transaction is outstanding.
//
// Ports:
//   clk, rst             clock; asynchronous active-high reset
//   if_req_i, if_addr_i  IF request and address (size is always word)
//   if_ready_o, if_data_o IF response pulse and data
//   flush_i              squash the in-flight IF response
//   mem_req_i, mem_addr_i, mem_size_i  MEM request, address and size
//   mem_ready_o, mem_data_o            MEM response pulse and data
//   rd_valid_o, rd_addr_o, rd_size_o   request side of the read master
//   rd_done_i, rd_data_i               completion pulse and data from it
// ----------------------------------------------------------------------------
module ysyx_22040759_rdarb #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64
) (
   input  logic                  clk,
   input  logic                  rst,

   input  logic                  if_req_i,
   input  logic [ADDR_WIDTH-1:0] if_addr_i,
   output logic                  if_ready_o,
   output logic [DATA_WIDTH-1:0] if_data_o,
   input  logic                  flush_i,

   input  logic                  mem_req_i,
   input  logic [ADDR_WIDTH-1:0] mem_addr_i,
   input  logic [1:0]            mem_size_i,
   output logic                  mem_ready_o,
   output logic [DATA_WIDTH-1:0] mem_data_o,

   output logic                  rd_valid_o,
   output logic [ADDR_WIDTH-1:0] rd_addr_o,
   output logic [1:0]            rd_size_o,
   input  logic                  rd_done_i,
   input  logic [DATA_WIDTH-1:0] rd_data_i
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   // Grant encoding: 0 = IF, 1 = MEM.
   localparam logic GNT_IF  = 1'b0;
   localparam logic GNT_MEM = 1'b1;

   localparam logic [1:0] SIZE_WORD = 2'b10;

   state_t                state_q;
   state_t                state_d;
   logic                  grant_q;
   logic                  grant_d;
   logic                  last_grant_q;
   logic                  kill_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [1:0]            size_q;
   logic [DATA_WIDTH-1:0] if_data_q;
   logic [DATA_WIDTH-1:0] mem_data_q;
   logic                  any_req;

   assign any_req = if_req_i | mem_req_i;

   // ------------------------------------------------------------------
   // Next-state and grant selection
   // ------------------------------------------------------------------
   always_comb begin
      state_d = state_q;
      grant_d = GNT_IF;

      // On a tie the requester that was not served last wins, so neither
      // side can starve the other.
      if (if_req_i && mem_req_i) begin
         grant_d = ~last_grant_q;
      end else if (mem_req_i) begin
         grant_d = GNT_MEM;
      end else begin
         grant_d = GNT_IF;
      end

      case (state_q)
         IDLE: begin
            if (any_req) begin
               state_d = BUSY;
            end
         end
         BUSY: begin
            if (rd_done_i) begin
               state_d = RESP;
            end
         end
         RESP: begin
            // Always pass through IDLE so a requester still holding its
            // request during its own response cycle is not re-granted.
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State, latched request and response data
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         grant_q      <= GNT_IF;
         last_grant_q <= GNT_IF;
         kill_q       <= 1'b0;
         addr_q       <= '0;
         size_q       <= '0;
         if_data_q    <= '0;
         mem_data_q   <= '0;
      end else begin
         state_q <= state_d;

         case (state_q)
            IDLE: begin
               // A flush arriving together with a new IF grant belongs to the
               // previous fetch, so the fresh grant starts with kill cleared.
               if (any_req) begin
                  grant_q <= grant_d;
                  kill_q  <= 1'b0;
                  if (grant_d == GNT_MEM) begin
                     addr_q <= mem_addr_i;
                     size_q <= mem_size_i;
                  end else begin
                     addr_q <= if_addr_i;
                     size_q <= SIZE_WORD;
                  end
               end
            end
            BUSY: begin
               if (flush_i && (grant_q == GNT_IF)) begin
                  kill_q <= 1'b1;
               end
               if (rd_done_i) begin
                  last_grant_q <= grant_q;
                  // The data register is written even for a killed fetch;
                  // only the ready pulse is suppressed.
                  if (grant_q == GNT_MEM) begin
                     mem_data_q <= rd_data_i;
                  end else begin
                     if_data_q <= rd_data_i;
                  end
               end
            end
            RESP: begin
               if (flush_i && (grant_q == GNT_IF)) begin
                  kill_q <= 1'b1;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // ------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------
   // rd_valid_o drops on the same edge that takes rd_done_i, so the read
   // master never sees a lingering request when it returns to its idle state.
   assign rd_valid_o  = (state_q == BUSY);
   assign rd_addr_o   = addr_q;
   assign rd_size_o   = size_q;

   // A flush arriving in the response cycle itself still squashes the pulse;
   // kill_q would only take effect one cycle too late.
   assign if_ready_o  = (state_q == RESP) && (grant_q == GNT_IF) &&
                        !kill_q && !flush_i;
   assign mem_ready_o = (state_q == RESP) && (grant_q == GNT_MEM);

   assign if_data_o   = if_data_q;
   assign mem_data_o  = mem_data_q;

endmodule
